// File: rtl/dm_pkg.sv
// Shared width codes, clear-FSM encoding and byte-enable helper for dm_bytelane.
// Pure declarations; no timing or flow control.
// No backpressure.
package dm_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam logic [0:0] DM_IDLE  = 1'b0;
    localparam logic [0:0] DM_CLEAR = 1'b1;

    // Little-endian byte enables; half selects the pair addressed by lane[1].
    function automatic logic [3:0] byte_mask(input logic [1:0] width, input logic [1:0] lane);
        logic [3:0] m;
        case (width)
            WIDTH_BYTE: m = 4'b0001 << lane;
            WIDTH_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            WIDTH_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load lane extractor: selects byte/half/word from a 32-bit word and sign/zero extends.
// Latency: combinational.
// No backpressure.
module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*lane_i +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (width_i)
            WIDTH_BYTE: rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            WIDTH_HALF: rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default:    rdata_o = word_i;
        endcase
    end

endmodule

// File: rtl/dm_bytelane.sv
// M-stage data memory with byte/half/word access, error flag and sequential clear sweep.
// Latency: loads combinational, stores commit on the Clk edge; sweep takes 2^ADDR_W cycles.
// Backpressure: Busy high during the sweep; stores ignored and RData forced to 0. Trace: DM_TRACE_EN.
module dm_bytelane
    import dm_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Width,
    input  logic        Unsigned,
    input  logic        Clear,
    output logic [31:0] RData,
    output logic        Busy,
    output logic        AddrErr
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    logic [31:0]       mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    logic [31:0]       offset;
    logic [ADDR_W-1:0] index;
    logic [1:0]        lane;
    logic              range_err;
    logic              align_err;
    logic              store_en;
    logic [3:0]        mask;
    logic [31:0]       wdata_rep;
    logic [31:0]       rd_word;
    logic [31:0]       merged;
    logic [31:0]       ext_data;

    assign offset = Addr - BASE_ADDR;
    assign index  = offset[ADDR_W+1:2];
    assign lane   = Addr[1:0];

    // Wider compare so addresses below BASE_ADDR wrap to huge offsets and fault.
    assign range_err = {1'b0, offset} >= LIMIT;

    always_comb begin
        case (Width)
            WIDTH_BYTE: align_err = 1'b0;
            WIDTH_HALF: align_err = Addr[0];
            WIDTH_WORD: align_err = (Addr[1:0] != 2'b00);
            default:    align_err = 1'b1;
        endcase
    end

    assign AddrErr = (MemRead | MemWrite) & (range_err | align_err);
    assign Busy    = (state_q == DM_CLEAR);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            DM_IDLE: begin
                if (Clear) begin
                    state_d = DM_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = DM_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= DM_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rd_word  = mem[index];
    assign mask     = byte_mask(Width, lane);
    assign store_en = MemWrite & ~Busy & ~AddrErr;

    always_comb begin
        case (Width)
            WIDTH_BYTE: wdata_rep = {4{WData[7:0]}};
            WIDTH_HALF: wdata_rep = {2{WData[15:0]}};
            default:    wdata_rep = WData;
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = mask[b] ? wdata_rep[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    // Array deliberately has no reset; the sweep zeroes it.
    always_ff @(posedge Clk) begin
        if (Busy) begin
            mem[ptr_q] <= '0;
        end else if (store_en) begin
            mem[index] <= merged;
        end
    end

`ifdef DM_TRACE_EN
    always @(posedge Clk) begin
        if (store_en) begin
            $display("*%h <= %h", BASE_ADDR + (32'(index) << 2), merged);
        end
    end
`endif

    dm_lane_ext u_lane_ext (
        .word_i     (rd_word),
        .lane_i     (lane),
        .width_i    (Width),
        .unsigned_i (Unsigned),
        .rdata_o    (ext_data)
    );

    assign RData = (Busy | AddrErr) ? 32'h0 : ext_data;

endmodule

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
Parametrised data memory for the M stage of the pipelined MIPS core; next generation of the word-only data memory. Adds:
- byte, halfword and word loads and stores, with sign or zero extension;
- alignment and range error flag;
- configurable depth and base address;
- sequential clear engine: one word per cycle after reset or on request, with Busy for the hazard unit to stall on.

Parameters:
ADDR_W, 10, word-index width; depth = 2^ADDR_W words of 32 bits
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
Addr  input  32  byte address (ALU result in M stage)
WData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
MemWrite  input  1  store strobe
MemRead  input  1  load strobe (qualifies AddrErr only)
Width  input  2  00 byte, 01 half, 10 word, 11 illegal
Unsigned  input  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
Clear  input  1  request full memory clear (single-cycle pulse)
RData  output  32  load data, extended, combinational
Busy  output  1  clear sweep in progress
AddrErr  output  1  misaligned, out-of-range or illegal-width access

Behaviour:
- Reset low (async): state <- CLEAR, clear pointer <- 0, Busy = 1.
  - Memory array has no reset; it is zeroed by the sweep after Reset rises.
  - Reset going low mid-sweep restarts the sweep from index 0.
- FSM has two states.
  - IDLE: Clear=1 -> CLEAR with pointer 0.
  - CLEAR: each cycle writes 0 to mem[pointer] and increments pointer. At pointer = 2^ADDR_W-1 the last word is written, then -> IDLE.
  - Sweep length is exactly 2^ADDR_W cycles after Reset release or after the Clear edge.
  - Busy = (state == CLEAR), registered; no combinational dependence on Clear.
  - Clear while in CLEAR is ignored (no restart).
- While Busy:
  - MemWrite is ignored;
  - RData = 0;
  - AddrErr is still computed.
- Decode: offset = Addr - BASE_ADDR; index = offset[ADDR_W+1:2]; lane = Addr[1:0].
- AddrErr = (MemRead | MemWrite) & (any of):
  - offset >= 4*2^ADDR_W, unsigned compare, so addresses below BASE_ADDR wrap and count as out of range;
  - Width==01 & Addr[0];
  - Width==10 & Addr[1:0]!=0;
  - Width==11.
  - AddrErr is combinational.
- A store with AddrErr=1 is suppressed (no array change). A load with AddrErr=1 returns RData=0.
- Stores commit on the rising Clk edge; little-endian byte lanes.
  - Byte: WData[7:0] -> lane byte.
  - Half: WData[15:0] -> bytes {Addr[1],0}..{Addr[1],1}.
  - Word: all four bytes.
  - Unselected bytes are preserved.
- Loads: combinational read of mem[index], lane extract, then extension per Unsigned.
  - Width==10 ignores Unsigned.
  - A load in the same cycle as a store to the same word returns the old contents; the new value is visible after the edge.
- Simultaneous Clear pulse and MemWrite in IDLE: the store commits this edge, then the sweep starts next cycle and zeroes it.

Optional Feature:
- Macro DM_TRACE_EN.
- Defined: every committed store issues $display("*%h <= %h", byte address of word, merged 32-bit word), with address = BASE_ADDR + 4*index. Suppressed, faulting and clear-sweep writes are not printed.
- Undefined: no simulation output; RTL otherwise identical.

Decomposition:
- Package dm_pkg:
  - width codes WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10;
  - state encoding DM_IDLE/DM_CLEAR.
- One sub-module, dm_lane_ext (combinational): takes word, lane, Width, Unsigned and produces extended RData. The top holds the array, store merge, error decode and clear FSM.

Test Plan:
- Reset low 3 cycles, release -> Busy=1 for exactly 1024 cycles then 0; lw 0x0 -> RData=0, AddrErr=0.
- sw 0x11223344 @0x8; sb 0xAA @0x9; lw @0x8 -> 0x1122AA44; lb @0x9 -> 0xFFFFFFAA; lbu @0x9 -> 0x000000AA.
- sh 0x8001 @0xE; lh @0xE -> 0xFFFF8001; lhu -> 0x00008001; lw @0xC -> 0x8001xxxx with low half unchanged.
- sw @0x6 or lh @0x3 -> AddrErr=1, memory unchanged, RData=0; sw @0x1000 (ADDR_W=10) -> AddrErr=1; Width=11 -> AddrErr=1.
- Write 0xDEADBEEF @0x20, pulse Clear -> Busy 1024 cycles, sw during Busy ignored, lw @0x20 afterwards -> 0.
- Reset low at sweep cycle 500 -> sweep restarts at 0, Busy lasts 1024 cycles after release; BASE_ADDR=0x1000_0000 instance: sw @0x1000_0004 works, sw @0x0FFF_FFFC -> AddrErr=1.
